// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers one FU result per port and broadcasts one per cycle on the CDB
package rv32i_types;
  typedef struct packed {
    logic [5:0]  rob_index;
    logic [6:0]  pd;
    logic [31:0] result;
    logic        branch_flag;
  } cdb_t;
endpackage

module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int N_FU  = 3,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_FU-1:0]       fu_cdb_valid,
  input  cdb_t [N_FU-1:0]       fu_cdb,
  output logic [N_FU-1:0]       fu_cdb_ready,
  input  logic                  branch_flush,
  output logic                  cdb_out_valid,
  output cdb_t                  cdb_out,
  output logic [CNT_W-1:0]      broadcast_count,
  output logic [CNT_W-1:0]      conflict_count
);
  localparam int PW = $clog2(N_FU);
  logic [N_FU-1:0] buf_valid, grant, xfer;
  cdb_t [N_FU-1:0] bufs;
  logic [PW-1:0]   rr_ptr, g;
  logic            gv;
  assign fu_cdb_ready = (rst || branch_flush) ? '0 : (~buf_valid | grant);
  assign xfer         = fu_cdb_valid & fu_cdb_ready;
  assign grant        = gv ? (N_FU'(1) << g) : '0;
  // round-robin scan from rr_ptr; a buffered mispredicted branch beats everything else
  always_comb begin
    logic          hv, lv;
    logic [PW-1:0] hg, lg;
    int            j;
    hv = 1'b0;
    lv = 1'b0;
    hg = '0;
    lg = '0;
    j  = 0;
    for (int k = 0; k < N_FU; k++) begin
      j = (int'(rr_ptr) + k) % N_FU;
      if (buf_valid[j] && bufs[j].branch_flag && !hv) begin
        hv = 1'b1;
        hg = PW'(j);
      end
      if (buf_valid[j] && !bufs[j].branch_flag && !lv) begin
        lv = 1'b1;
        lg = PW'(j);
      end
    end
    gv = hv || lv;
    g  = hv ? hg : lg;
  end
  // buffer capture, broadcast register, pointer and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid       <= '0;
      bufs            <= '0;
      rr_ptr          <= '0;
      cdb_out_valid   <= 1'b0;
      cdb_out         <= '0;
      broadcast_count <= '0;
      conflict_count  <= '0;
    end else if (branch_flush) begin
      buf_valid     <= '0;
      cdb_out_valid <= 1'b0;
      cdb_out       <= '0;
    end else begin
      buf_valid <= (buf_valid & ~grant) | xfer;
      for (int i = 0; i < N_FU; i++)
        if (xfer[i]) bufs[i] <= fu_cdb[i];
      cdb_out_valid <= gv;
      cdb_out       <= gv ? bufs[g] : '0;
      if (gv) begin
        rr_ptr          <= (g == PW'(N_FU - 1)) ? '0 : g + PW'(1);
        broadcast_count <= broadcast_count + CNT_W'(1);
      end
      if ($countones(buf_valid) > 1) conflict_count <= conflict_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for the CDB arbiter
module tb_cdb_arbiter;
  import rv32i_types::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  fu_cdb_valid = '0;
  cdb_t [2:0]  fu_cdb = '0;
  logic [2:0]  fu_cdb_ready;
  logic        branch_flush = 1'b0;
  logic        cdb_out_valid;
  cdb_t        cdb_out;
  logic [31:0] broadcast_count, conflict_count;
  logic [2:0]  taken = '0;
  int          cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;
  int          c0;
  typedef struct {
    cdb_t p;
    int   c;
  } exp_t;
  exp_t q[$];

  cdb_arbiter #(.N_FU(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .fu_cdb_valid(fu_cdb_valid), .fu_cdb(fu_cdb),
    .fu_cdb_ready(fu_cdb_ready), .branch_flush(branch_flush),
    .cdb_out_valid(cdb_out_valid), .cdb_out(cdb_out),
    .broadcast_count(broadcast_count), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record which offers the arbiter accepted this cycle
  initial forever begin
    @(negedge clk);
    taken = fu_cdb_valid & fu_cdb_ready;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cdb_t mk(input logic [5:0] r, input logic [31:0] v, input logic f);
    cdb_t x;
    x.rob_index   = r;
    x.pd          = {1'b0, r};
    x.result      = v;
    x.branch_flag = f;
    return x;
  endfunction

  // monitor: every broadcast must match the oldest expected result and its cycle
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (cdb_out_valid) begin
      if (q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_broadcast: got rob %0d result %0h expected none (cycle %0d)",
                 cdb_out.rob_index, cdb_out.result, cyc);
      end else begin
        e = q.pop_front();
        check("bcast_payload", 64'(cdb_out), 64'(e.p));
        check("bcast_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    fu_cdb_valid = fu_cdb_valid & ~taken;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_at(input cdb_t p, input int c);
    exp_t e;
    e.p = p;
    e.c = c;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    repeat (3) step();
  endtask

  task automatic rst_dut();
    rst = 1'b1;
    branch_flush = 1'b0;
    fu_cdb_valid = '0;
    step();
    step();
    sample();
    check("rst_ready", 64'(fu_cdb_ready), 64'(0));
    step();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    rst_dut();
    sample();
    check("rst_valid", 64'(cdb_out_valid), 64'(0));
    check("rst_bcnt", 64'(broadcast_count), 64'(0));
    check("rst_ccnt", 64'(conflict_count), 64'(0));
    check("rst_ready_after", 64'(fu_cdb_ready), 64'(3'b111));
    // single ALU result
    rst_dut();
    c0 = cyc;
    fu_cdb[0] = mk(6'd5, 32'h1234, 1'b0);
    fu_cdb_valid = 3'b001;
    expect_at(fu_cdb[0], c0 + 2);
    sample();
    check("t1_ready", 64'(fu_cdb_ready[0]), 64'(1));
    step();
    drain();
    check("t1_bcnt", 64'(broadcast_count), 64'(1));
    // three simultaneous results, round-robin from 0
    rst_dut();
    c0 = cyc;
    fu_cdb[0] = mk(6'd10, 32'hA0, 1'b0);
    fu_cdb[1] = mk(6'd11, 32'hA1, 1'b0);
    fu_cdb[2] = mk(6'd12, 32'hA2, 1'b0);
    fu_cdb_valid = 3'b111;
    expect_at(fu_cdb[0], c0 + 2);
    expect_at(fu_cdb[1], c0 + 3);
    expect_at(fu_cdb[2], c0 + 4);
    sample();
    check("t2_ready_c0", 64'(fu_cdb_ready), 64'(3'b111));
    step();
    sample();
    check("t2_ready_c1", 64'(fu_cdb_ready), 64'(3'b001));
    step();
    sample();
    check("t2_ready_c2", 64'(fu_cdb_ready), 64'(3'b011));
    drain();
    check("t2_ccnt", 64'(conflict_count), 64'(2));
    check("t2_bcnt", 64'(broadcast_count), 64'(3));
    check("t2_rr", 64'(dut.rr_ptr), 64'(0));
    // port 0 streams six results back to back
    rst_dut();
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      fu_cdb[0] = mk(6'(20 + k), 32'h100 + 32'(k), 1'b0);
      fu_cdb_valid = 3'b001;
      expect_at(fu_cdb[0], c0 + k + 2);
      sample();
      check("t3_ready", 64'(fu_cdb_ready[0]), 64'(1));
      step();
    end
    drain();
    check("t3_ccnt", 64'(conflict_count), 64'(0));
    check("t3_bcnt", 64'(broadcast_count), 64'(6));
    // branch-flagged result on port 1 overtakes port 0
    rst_dut();
    c0 = cyc;
    fu_cdb[0] = mk(6'd30, 32'hB0, 1'b0);
    fu_cdb[1] = mk(6'd31, 32'hB1, 1'b1);
    fu_cdb_valid = 3'b011;
    expect_at(fu_cdb[1], c0 + 2);
    expect_at(fu_cdb[0], c0 + 3);
    step();
    step();
    sample();
    check("t4_rr", 64'(dut.rr_ptr), 64'(2));
    drain();
    check("t4_bcnt", 64'(broadcast_count), 64'(2));
    // flush discards buffered results and refuses new offers
    rst_dut();
    fu_cdb[0] = mk(6'd40, 32'hC0, 1'b0);
    fu_cdb[2] = mk(6'd42, 32'hC2, 1'b0);
    fu_cdb_valid = 3'b101;
    step();
    branch_flush = 1'b1;
    fu_cdb[1] = mk(6'd41, 32'hC1, 1'b0);
    fu_cdb_valid = 3'b010;
    sample();
    check("t5_ready_flush", 64'(fu_cdb_ready), 64'(0));
    step();
    branch_flush = 1'b0;
    fu_cdb_valid = '0;
    sample();
    check("t5_ready_after", 64'(fu_cdb_ready), 64'(3'b111));
    check("t5_bufs", 64'(dut.buf_valid), 64'(0));
    check("t5_out", 64'(cdb_out), 64'(0));
    repeat (4) step();
    check("t5_bcnt", 64'(broadcast_count), 64'(0));
    check("t5_ccnt", 64'(conflict_count), 64'(0));
    // reset while buffers are full and the bus is busy
    rst_dut();
    c0 = cyc;
    fu_cdb[0] = mk(6'd50, 32'hD0, 1'b0);
    fu_cdb[1] = mk(6'd51, 32'hD1, 1'b0);
    fu_cdb[2] = mk(6'd52, 32'hD2, 1'b0);
    fu_cdb_valid = 3'b111;
    expect_at(fu_cdb[0], c0 + 2);
    step();
    step();
    rst = 1'b1;
    sample();
    check("t6_busy", 64'(cdb_out_valid), 64'(1));
    check("t6_ready_rst", 64'(fu_cdb_ready), 64'(0));
    step();
    rst = 1'b0;
    sample();
    check("t6_valid", 64'(cdb_out_valid), 64'(0));
    check("t6_out", 64'(cdb_out), 64'(0));
    check("t6_bcnt", 64'(broadcast_count), 64'(0));
    check("t6_ccnt", 64'(conflict_count), 64'(0));
    check("t6_ready", 64'(fu_cdb_ready), 64'(3'b111));
    check("t6_bufs", 64'(dut.buf_valid), 64'(0));
    drain();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
